// File: rtl/seg_scan_if.sv
// Display-side bundle for the 2-digit seven-segment scan controller.
// The value source drives bin_in/load; the display consumes an/seg/frame_done.
interface seg_scan_if;
  logic [3:0] bin_in;
  logic       load;
  logic [1:0] an;
  logic [6:0] seg;
  logic       frame_done;

  modport master (
    output bin_in,
    output load,
    input  an,
    input  seg,
    input  frame_done
  );

  modport slave (
    input  bin_in,
    input  load,
    output an,
    output seg,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Two-digit time-multiplexed 7-segment scanner for a 0..15 value.
// The displayed value only changes at frame boundaries, so a frame never tears.
module seg_scan_controller #(
  parameter int DIV_CNT       = 50000,
  parameter int DEAD_CYC      = 1,
  parameter int ANODE_ACT_LOW = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);

  localparam int CW = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CNT - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);

  localparam logic [1:0] AN_OFF = (ANODE_ACT_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic [1:0] AN_U   = (ANODE_ACT_LOW != 0) ? 2'b10 : 2'b01;
  localparam logic [1:0] AN_T   = (ANODE_ACT_LOW != 0) ? 2'b01 : 2'b10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UNITS,
    S_TENS
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          term;
  logic          dead;
  logic          boundary;

  logic [3:0] pending;
  logic       pend_vld;
  logic [3:0] shown;
  logic       tens;
  logic [3:0] units;

  logic [1:0] an_d;
  logic [6:0] seg_d;
  logic       fd_d;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_OFF;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  assign term     = (cnt == CNT_LAST);
  assign dead     = (cnt < CNT_DEAD);
  assign boundary = (state == S_IDLE) ||
                    ((state == S_TENS) && term);

  assign tens  = (shown >= 4'd10);
  assign units = tens ? shown - 4'd10 : shown;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  nxt = S_UNITS;
      S_UNITS: if (term) nxt = S_TENS;
      S_TENS:  if (term) nxt = S_UNITS;
      default: nxt = S_IDLE;
    endcase
  end

  // A load coinciding with the boundary bypasses pending entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 4'd0;
      pend_vld <= 1'b0;
      shown    <= 4'd0;
    end else if (boundary) begin
      pend_vld <= 1'b0;
      if (bus.load)
        shown <= bus.bin_in;
      else if (pend_vld)
        shown <= pending;
    end else if (bus.load) begin
      pending  <= bus.bin_in;
      pend_vld <= 1'b1;
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    fd_d  = 1'b0;
    unique case (state)
      S_UNITS: begin
        if (!dead) begin
          an_d  = AN_U;
          seg_d = enc(units);
        end
      end
      S_TENS: begin
        fd_d = term;
        if (!dead && !((BLANK_LEADING != 0) && !tens)) begin
          an_d  = AN_T;
          seg_d = enc({3'b000, tens});
        end
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.frame_done <= 1'b0;
    end else begin
      bus.an         <= an_d;
      bus.seg        <= seg_d;
      bus.frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: frame-level reference model plus
// hand-computed display checkpoints and randomized load/reset traffic.
module tb_seg_scan_controller;

  localparam int DIV  = 4;
  localparam int DEAD = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_if bus ();

  seg_scan_controller #(
    .DIV_CNT(DIV),
    .DEAD_CYC(DEAD),
    .ANODE_ACT_LOW(1),
    .BLANK_LEADING(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] enc_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: the scan is a free-running position p since leaving idle;
  // slot = (p / DIV) % 2, offset = p % DIV. Outputs lag that by one edge.
  initial begin
    bit         m_valid;
    bit         idle;
    int         p;
    int         shown;
    int         pend;
    bit         pvld;
    bit         s_rst;
    bit         s_load;
    int         s_bin;
    int         slot;
    int         c;
    bit         bnd;
    logic [1:0] e_an;
    logic [6:0] e_seg;
    logic       e_fd;
    m_valid = 0;
    idle = 1;
    p = 0;
    shown = 0;
    pend = 0;
    pvld = 0;
    forever begin
      @(posedge clk);
      s_rst  = rst;
      s_load = bus.load;
      s_bin  = int'(bus.bin_in);
      @(negedge clk);
      if (s_rst) begin
        m_valid = 1;
        idle = 1;
        p = 0;
        shown = 0;
        pend = 0;
        pvld = 0;
        e_an = 2'b11;
        e_seg = 7'h7F;
        e_fd = 1'b0;
      end else if (m_valid) begin
        e_an = 2'b11;
        e_seg = 7'h7F;
        e_fd = 1'b0;
        if (!idle) begin
          slot = (p / DIV) % 2;
          c = p % DIV;
          if (c >= DEAD) begin
            if (slot == 0) begin
              e_an = 2'b10;
              e_seg = enc_tab[shown % 10];
            end else if (shown >= 10) begin
              e_an = 2'b01;
              e_seg = enc_tab[1];
            end
          end
          e_fd = (slot == 1) && (c == DIV - 1);
        end
        bnd = idle || e_fd;
        if (bnd) begin
          if (s_load) shown = s_bin;
          else if (pvld) shown = pend;
          pvld = 0;
        end else if (s_load) begin
          pend = s_bin;
          pvld = 1;
        end
        if (idle) begin
          idle = 0;
          p = 0;
        end else begin
          p++;
        end
      end
      if (m_valid) begin
        chk("an", {30'd0, bus.an}, {30'd0, e_an});
        chk("seg", {25'd0, bus.seg}, {25'd0, e_seg});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, e_fd});
        chk("an_both_on", {31'd0, bus.an == 2'b00}, 32'd0);
      end
    end
  end

  task automatic load_val(input int v);
    @(posedge clk);
    #1;
    bus.load = 1'b1;
    bus.bin_in = 4'(v);
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  // Returns at the negedge where frame_done is seen.
  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 40);
    chk("fd_timeout", {31'd0, bus.frame_done}, 32'd1);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.bin_in = 4'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", {30'd0, bus.an}, 32'h3);
    chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
    chk("rst_fd", {31'd0, bus.frame_done}, 32'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("first_units_an", {30'd0, bus.an}, 32'h2);
    chk("first_units_seg", {25'd0, bus.seg}, 32'h40);

    load_val(13);
    wait_fd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("u13_an", {30'd0, bus.an}, 32'h2);
    chk("u13_seg", {25'd0, bus.seg}, {25'd0, 7'b0110000});
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t13_an", {30'd0, bus.an}, 32'h1);
    chk("t13_seg", {25'd0, bus.seg}, {25'd0, 7'b1111001});

    load_val(5);
    wait_fd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("u5_seg", {25'd0, bus.seg}, {25'd0, 7'b0010010});
    repeat (2) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t5_blank", {30'd0, bus.an}, 32'h3);
    end
    chk("fd_period", {31'd0, bus.frame_done}, 32'd1);

    @(posedge clk);
    #1;
    bus.load = 1'b1;
    bus.bin_in = 4'd7;
    @(posedge clk);
    #1 bus.bin_in = 4'd12;
    @(posedge clk);
    #1 bus.load = 1'b0;
    wait_fd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("u12_an", {30'd0, bus.an}, 32'h2);
    chk("u12_seg", {25'd0, bus.seg}, {25'd0, 7'b0100100});
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t12_an", {30'd0, bus.an}, 32'h1);

    wait_fd();
    repeat (7) @(posedge clk);
    #1;
    bus.load = 1'b1;
    bus.bin_in = 4'd9;
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("u9_coincident", {25'd0, bus.seg}, {25'd0, 7'b0010000});

    wait_fd();
    @(posedge clk);
    #1;
    bus.load = 1'b1;
    bus.bin_in = 4'd4;
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_an", {30'd0, bus.an}, 32'h3);
    chk("midrst_seg", {25'd0, bus.seg}, 32'h7F);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("postrst_seg", {25'd0, bus.seg}, 32'h40);

    for (int v = 0; v < 16; v++) begin
      load_val(v);
      wait_fd();
      wait_fd();
    end

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      bus.load = ($urandom_range(0, 4) == 0);
      bus.bin_in = 4'($urandom_range(0, 15));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.load = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
